// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr_pkg: mode constants and width helper shared by the stream mux files.
package stream_mux_rr_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick of the first requester at or after ptr_i.
module rr_arbiter_n #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] gnt_o,
    output logic             gnt_valid_o
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the requester closest to ptr_i overwrites the rest.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(ptr_i) + k) % N_CH);
            if (req_i[idx]) begin
                gnt_o       = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-aware N-channel stream mux with round-robin or fixed select,
// holding the grant for a whole packet and driving a single registered output beat.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = clog2(N_CH),
    parameter int MODE  = MODE_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             locked_q, locked_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] arb_ch, cur;
    logic             arb_valid, grant, load, xfer;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter_n #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_ch),
        .gnt_valid_o (arb_valid)
    );

    // A held lock always wins; otherwise the mode decides who owns the next packet.
    assign cur   = locked_q ? lock_ch_q : (MODE == MODE_FIXED) ? sel : arb_ch;
    assign grant = locked_q || ((MODE == MODE_FIXED) ? (int'(sel) < N_CH) : arb_valid);
    assign load  = !out_valid_q || out_ready;
    assign xfer  = load && grant && in_valid[cur];

    assign in_ready = (load && grant && !rst) ? (N_CH'(1) << cur) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = ch_data[cur];
                out_last_d = in_last[cur];
                out_ch_d   = cur;
                locked_d   = !in_last[cur];
                lock_ch_d  = in_last[cur] ? lock_ch_q : cur;
                rr_ptr_d   = !in_last[cur] ? rr_ptr_q :
                             (cur == SEL_W'(N_CH - 1)) ? '0 : cur + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table, directed and randomized-model checks of stream_mux_rr
// in round-robin (4 and 3 channels) and fixed-select (3 channels) configurations.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_data = '0;
    logic [3:0]  a_vld = '0, a_last = '0, a_rdy;
    logic [1:0]  a_sel = '0, a_och;
    logic [3:0]  a_od;
    logic        a_ov, a_ol, a_ordy = 1'b1;

    logic [11:0] b_data = '0, c_data = '0;
    logic [2:0]  b_vld = '0, b_last = '0, b_rdy, c_vld = '0, c_last = '0, c_rdy;
    logic [1:0]  b_sel = '0, b_och, c_sel = '0, c_och;
    logic [3:0]  b_od, c_od;
    logic        b_ov, b_ol, c_ov, c_ol;

    stream_mux_rr #(.WIDTH(4), .N_CH(4), .SEL_W(2), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_vld), .in_last(a_last),
        .in_ready(a_rdy), .sel(a_sel), .out_data(a_od), .out_valid(a_ov),
        .out_last(a_ol), .out_ch(a_och), .out_ready(a_ordy));

    stream_mux_rr #(.WIDTH(4), .N_CH(3), .SEL_W(2), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_vld), .in_last(b_last),
        .in_ready(b_rdy), .sel(b_sel), .out_data(b_od), .out_valid(b_ov),
        .out_last(b_ol), .out_ch(b_och), .out_ready(1'b1));

    stream_mux_rr #(.WIDTH(4), .N_CH(3), .SEL_W(2), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_vld), .in_last(c_last),
        .in_ready(c_rdy), .sel(c_sel), .out_data(c_od), .out_valid(c_ov),
        .out_last(c_ol), .out_ch(c_och), .out_ready(1'b1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  vld, last;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [3:0]  e_d;
        logic [1:0]  e_ch;
        logic        e_l;
    } vec_t;

    vec_t tbl [20];

    // Random-phase producer state and reference model (owner = -1 when no packet is open)
    bit         pv [4];
    bit         pl [4];
    logic [3:0] pd [4];
    int owner, ptr, mch, c;
    bit mv, ml, load, xfer;
    logic [3:0] md, erdy;

    initial begin
        // single-beat round robin, 3-beat lock on ch1, backpressure and a mid-packet bubble on ch3
        tbl[0]  = '{4'b1111, 4'b1111, 16'h3210, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 16'h3210, 1'b1, 4'b0010, 1'b1, 4'h0, 2'd0, 1'b1};
        tbl[2]  = '{4'b1111, 4'b1111, 16'h3210, 1'b1, 4'b0100, 1'b1, 4'h1, 2'd1, 1'b1};
        tbl[3]  = '{4'b1111, 4'b1111, 16'h3210, 1'b1, 4'b1000, 1'b1, 4'h2, 2'd2, 1'b1};
        tbl[4]  = '{4'b1111, 4'b1111, 16'h3210, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd3, 1'b1};
        tbl[5]  = '{4'b0111, 4'b0101, 16'h02A0, 1'b1, 4'b0010, 1'b1, 4'h0, 2'd0, 1'b1};
        tbl[6]  = '{4'b0111, 4'b0101, 16'h02B0, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd1, 1'b0};
        tbl[7]  = '{4'b0111, 4'b0111, 16'h02C0, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1, 1'b0};
        tbl[8]  = '{4'b0101, 4'b0101, 16'h0200, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'h2, 2'd2, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd2, 1'b1};
        tbl[11] = '{4'b1000, 4'b0000, 16'h5000, 1'b1, 4'b1000, 1'b0, 4'h2, 2'd2, 1'b1};
        tbl[12] = '{4'b1000, 4'b0000, 16'h6000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd3, 1'b0};
        tbl[13] = '{4'b1000, 4'b0000, 16'h6000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd3, 1'b0};
        tbl[14] = '{4'b1000, 4'b0000, 16'h6000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd3, 1'b0};
        tbl[15] = '{4'b1000, 4'b0000, 16'h6000, 1'b1, 4'b1000, 1'b1, 4'h5, 2'd3, 1'b0};
        tbl[16] = '{4'b0101, 4'b0101, 16'h0000, 1'b1, 4'b1000, 1'b1, 4'h6, 2'd3, 1'b0};
        tbl[17] = '{4'b1000, 4'b1000, 16'h7000, 1'b1, 4'b1000, 1'b0, 4'h6, 2'd3, 1'b0};
        tbl[18] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'h7, 2'd3, 1'b1};
        tbl[19] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h7, 2'd3, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(a_ov), 32'd0);
        chk("reset in_ready", 32'(a_rdy), 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_vld = tbl[i].vld; a_last = tbl[i].last; a_data = tbl[i].data; a_ordy = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d in_ready", i), 32'(a_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d out_valid", i), 32'(a_ov), 32'(tbl[i].e_v));
            chk($sformatf("tbl%0d out_data", i), 32'(a_od), 32'(tbl[i].e_d));
            chk($sformatf("tbl%0d out_ch", i), 32'(a_och), 32'(tbl[i].e_ch));
            chk($sformatf("tbl%0d out_last", i), 32'(a_ol), 32'(tbl[i].e_l));
        end

        // async reset while a packet on ch2 is stalled at the output
        @(negedge clk);
        a_vld = 4'b0100; a_last = '0; a_data = 16'h0400; a_ordy = 1'b1;
        #1 chk("rst pre in_ready", 32'(a_rdy), 32'b0100);
        @(negedge clk);
        a_data = 16'h0500; a_ordy = 1'b0;
        #1 chk("rst pre out_data", 32'(a_od), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("rst async out_valid", 32'(a_ov), 32'd0);
        chk("rst async out_ch", 32'(a_och), 32'd0);
        chk("rst async out_data", 32'(a_od), 32'd0);
        chk("rst async in_ready", 32'(a_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0; a_vld = '0; a_ordy = 1'b1;
        #1 chk("post rst idle0", 32'(a_ov), 32'd0);
        @(negedge clk);
        #1 chk("post rst idle1", 32'(a_ov), 32'd0);
        @(negedge clk);
        a_vld = 4'b0001; a_last = 4'b0001; a_data = 16'h0003;
        #1 chk("post rst lock cleared", 32'(a_rdy), 32'b0001);
        @(negedge clk);
        a_vld = '0;
        #1;
        chk("post rst beat valid", 32'(a_ov), 32'd1);
        chk("post rst beat data", 32'(a_od), 32'h3);

        // fixed select on 3 channels: sel change mid-packet is ignored, sel=3 is out of range
        @(negedge clk);
        b_sel = 2'd2; b_vld = 3'b100; b_last = 3'b000; b_data = 12'h900;
        #1 chk("fix beat1 in_ready", 32'(b_rdy), 32'b100);
        @(negedge clk);
        b_sel = 2'd0; b_vld = 3'b111; b_last = 3'b101; b_data = 12'hA01;
        #1;
        chk("fix locked in_ready", 32'(b_rdy), 32'b100);
        chk("fix beat1 out_data", 32'(b_od), 32'h9);
        chk("fix beat1 out_ch", 32'(b_och), 32'd2);
        @(negedge clk);
        b_vld = 3'b001; b_last = 3'b001; b_data = 12'h001;
        #1;
        chk("fix next pkt in_ready", 32'(b_rdy), 32'b001);
        chk("fix beat2 out_data", 32'(b_od), 32'hA);
        chk("fix beat2 out_ch", 32'(b_och), 32'd2);
        chk("fix beat2 out_last", 32'(b_ol), 32'd1);
        @(negedge clk);
        b_sel = 2'd3; b_vld = 3'b111; b_last = 3'b111; b_data = 12'h000;
        #1;
        chk("fix sel3 in_ready", 32'(b_rdy), 32'd0);
        chk("fix ch0 out_ch", 32'(b_och), 32'd0);
        chk("fix ch0 out_data", 32'(b_od), 32'h1);
        @(negedge clk);
        #1;
        chk("fix sel3 in_ready2", 32'(b_rdy), 32'd0);
        chk("fix sel3 out_valid", 32'(b_ov), 32'd0);
        b_vld = '0;

        // 3-channel round robin wraps the pointer from ch2 back to ch0
        @(negedge clk);
        c_vld = 3'b100; c_last = 3'b100; c_data = 12'h800;
        #1 chk("wrap ch2 in_ready", 32'(c_rdy), 32'b100);
        @(negedge clk);
        c_vld = 3'b101; c_last = 3'b101; c_data = 12'h801;
        #1;
        chk("wrap ch0 in_ready", 32'(c_rdy), 32'b001);
        chk("wrap ch2 out_ch", 32'(c_och), 32'd2);
        @(negedge clk);
        c_vld = 3'b111; c_last = 3'b111; c_data = 12'h021;
        #1;
        chk("wrap ch1 in_ready", 32'(c_rdy), 32'b010);
        chk("wrap ch0 out_ch", 32'(c_och), 32'd0);
        chk("wrap ch0 out_data", 32'(c_od), 32'h1);
        @(negedge clk);
        c_vld = '0;
        #1 chk("wrap ch1 out_ch", 32'(c_och), 32'd1);

        // randomized traffic against a packet-ownership reference model
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        owner = -1; ptr = 0; mv = 0; md = '0; mch = 0; ml = 0;
        for (int j = 0; j < 4; j++) begin
            pv[j] = ($urandom_range(0, 2) != 0);
            pd[j] = 4'($urandom);
            pl[j] = ($urandom_range(0, 2) == 0);
        end
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            a_ordy = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) begin
                a_vld[j] = pv[j];
                a_last[j] = pl[j];
                a_data[j*4 +: 4] = pd[j];
            end
            #1;
            load = !mv || a_ordy;
            c = owner;
            if (c < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (c < 0 && pv[(ptr + k) % 4]) c = (ptr + k) % 4;
                end
            end
            erdy = (load && c >= 0) ? 4'(1 << c) : 4'd0;
            xfer = load && c >= 0 && pv[c];
            chk("rand in_ready", 32'(a_rdy), 32'(erdy));
            chk("rand out_valid", 32'(a_ov), 32'(mv));
            chk("rand out_data", 32'(a_od), 32'(md));
            chk("rand out_ch", 32'(a_och), 32'(mch));
            chk("rand out_last", 32'(a_ol), 32'(ml));
            @(posedge clk);
            if (load) begin
                mv = xfer;
                if (xfer) begin
                    md = pd[c]; ml = pl[c]; mch = c;
                    owner = pl[c] ? -1 : c;
                    if (pl[c]) ptr = (c + 1) % 4;
                end
            end
            for (int j = 0; j < 4; j++) begin
                if ((xfer && j == c) || !pv[j]) begin
                    pv[j] = ($urandom_range(0, 2) != 0);
                    pd[j] = 4'($urandom);
                    pl[j] = ($urandom_range(0, 2) == 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
